// File: rtl/mem_b_arbiter_if.sv
// mem_b_arbiter_if: two requester channels plus the memory port B bus of the arbiter. rev 1.0
`default_nettype none
`timescale 1ns/1ps

interface mem_b_arbiter_if;
  logic        r0_req;
  logic [3:0]  r0_we;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_done;
  logic        r0_err;
  logic        r1_req;
  logic [3:0]  r1_we;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_done;
  logic        r1_err;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic [3:0]  mem_start;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_done, r0_err, r1_done, r1_err,
    output rdata, busy, mem_addr, mem_start, mem_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_done, r0_err, r1_done, r1_err,
    input  rdata, busy, mem_addr, mem_start, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_b_arbiter.sv
// mem_b_arbiter: round-robin sharing of memory port B between two requesters,
// one IDLE/ACCESS/RESP transaction at a time. rev 1.0
`default_nettype none
`timescale 1ns/1ps

module mem_b_arbiter #(
  parameter int MEM_BYTES   = 1024,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_b_arbiter_if.slave  bus
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_gnt;
  logic        win;
  logic        grant;
  logic [3:0]  sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;
  logic [3:0]  we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        legal_q;
  logic [31:0] rdata_q;

  always_comb begin
    state_nxt = state;
    win       = 1'b0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester that was not granted last time wins.
        if (bus.r0_req && bus.r1_req) begin
          win   = ~last_gnt;
          grant = 1'b1;
        end else if (bus.r0_req) begin
          win   = 1'b0;
          grant = 1'b1;
        end else if (bus.r1_req) begin
          win   = 1'b1;
          grant = 1'b1;
        end
        if (grant) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_we    = win ? bus.r1_we    : bus.r0_we;
    sel_addr  = win ? bus.r1_addr  : bus.r0_addr;
    sel_wdata = win ? bus.r1_wdata : bus.r0_wdata;
    sel_legal = (sel_addr <= MAX_ADDR) && (!CHECK_ALIGN || (sel_addr[1:0] == 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      we_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      legal_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (state == IDLE && grant) begin
        last_gnt <= win;
        we_q     <= sel_we;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        legal_q  <= sel_legal;
      end
      if (state == ACCESS) rdata_q <= legal_q ? bus.mem_rdata : 32'h0;
    end
  end

  // Outputs depend on registers only; the async reset forces state to IDLE,
  // which drops mem_start immediately.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_start = (state == ACCESS && legal_q) ? we_q : 4'h0;
  assign bus.r0_done   = (state == RESP) && !last_gnt;
  assign bus.r1_done   = (state == RESP) && last_gnt;
  assign bus.r0_err    = bus.r0_done && !legal_q;
  assign bus.r1_err    = bus.r1_done && !legal_q;
  assign bus.rdata     = (state == RESP) ? rdata_q : 32'h0;
  assign bus.busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_b_arbiter.sv
// tb_mem_b_arbiter: randomized self-checking bench with a word-level memory reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_b_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_b_arbiter_if bus ();

  mem_b_arbiter #(.MEM_BYTES(1024), .CHECK_ALIGN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte-wide memory attached to port B.
  logic [7:0] mem [0:1023];
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (bus.mem_start[k]) mem[10'(bus.mem_addr[9:0] + 10'(k))] <= bus.mem_wdata[8*k +: 8];
  assign bus.mem_rdata = {mem[bus.mem_addr[9:0] + 10'd3], mem[bus.mem_addr[9:0] + 10'd2],
                          mem[bus.mem_addr[9:0] + 10'd1], mem[bus.mem_addr[9:0]]};

  // Reference model: 256 words, legality straight from the address rules.
  logic [31:0] ref_w [0:255];
  int total = 0;
  int bad   = 0;

  function automatic bit is_legal(logic [31:0] a);
    return (a <= 32'd1020) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return is_legal(a) ? ref_w[a[9:2]] : 32'h0;
  endfunction

  function automatic void ref_write(logic [31:0] a, logic [3:0] we, logic [31:0] wd);
    if (is_legal(a))
      for (int k = 0; k < 4; k++)
        if (we[k]) ref_w[a[9:2]][8*k +: 8] = wd[8*k +: 8];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      3:       return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      4:       return 32'h3FC;
      default: return 32'h400 + 32'($urandom_range(0, 64));
    endcase
  endfunction

  task automatic drive(input bit n, input bit req, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] wd);
    if (n) begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = wd;
    end else begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = wd;
    end
  endtask

  // One single-requester transaction starting in an IDLE cycle; returns what was observed.
  task automatic do_txn(input bit n, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] wd, input bit scramble, input bit drop,
                        output logic [3:0] st_acc, output logic [3:0] st_other,
                        output logic [31:0] maddr, output logic dn, output logic extra,
                        output logic er, output logic [31:0] rd);
    drive(n, 1'b1, we, a, wd);
    #1 st_other = bus.mem_start;
    extra = bus.r0_done | bus.r1_done;
    @(posedge clk); #1;
    st_acc = bus.mem_start;
    maddr  = bus.mem_addr;
    extra  = extra | bus.r0_done | bus.r1_done;
    if (scramble) drive(n, 1'b1, 4'($urandom), $urandom, $urandom);
    if (drop) drive(n, 1'b0, n ? bus.r1_we : bus.r0_we, n ? bus.r1_addr : bus.r0_addr,
                    n ? bus.r1_wdata : bus.r0_wdata);
    @(posedge clk); #1;
    st_other = st_other | bus.mem_start;
    dn    = n ? bus.r1_done : bus.r0_done;
    extra = extra | (n ? bus.r0_done : bus.r1_done);
    er    = n ? bus.r1_err : bus.r0_err;
    rd    = bus.rdata;
    @(posedge clk); #1;
    drive(n, 1'b0, 4'h0, 32'h0, 32'h0);
    st_other = st_other | bus.mem_start;
    extra = extra | bus.r0_done | bus.r1_done;
    ref_write(a, we, wd);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.mem_start !== 4'h0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_start_busy: got start=%h busy=%b want 0 0", bus.mem_start, bus.busy); end
    total++; if ({bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err} !== 4'h0) begin
      bad++; $display("FAIL reset_done_err: got %b want 0000",
                      {bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err}); end
    total++; if (bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0", bus.rdata,
                      bus.mem_addr, bus.mem_wdata); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [3:0] sa, so; logic [31:0] ma, rd; logic dn, ex, er;
    do_txn(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (sa !== 4'hF || so !== 4'h0) begin
      bad++; $display("FAIL wr_start: got access=%h other=%h want F 0", sa, so); end
    total++; if (dn !== 1'b1 || ex !== 1'b0 || er !== 1'b0) begin
      bad++; $display("FAIL wr_done: got done=%b extra=%b err=%b want 1 0 0", dn, ex, er); end
    total++; if (ma !== 32'h10) begin
      bad++; $display("FAIL wr_addr: got %h want 00000010", ma); end
    do_txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (rd !== 32'hDEADBEEF || dn !== 1'b1 || sa !== 4'h0) begin
      bad++; $display("FAIL rd_back: got rdata=%h done=%b start=%h want deadbeef 1 0", rd, dn, sa); end
  endtask

  task automatic test_byte_write();
    logic [3:0] sa, so; logic [31:0] ma, rd; logic dn, ex, er;
    do_txn(1'b1, 4'b0010, 32'h10, 32'h0000AB00, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (sa !== 4'b0010 || dn !== 1'b1 || ex !== 1'b0) begin
      bad++; $display("FAIL byte_wr: got start=%h done=%b extra=%b want 2 1 0", sa, dn, ex); end
    do_txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (rd !== 32'hDEADABEF) begin
      bad++; $display("FAIL byte_rd: got %h want deadabef", rd); end
  endtask

  task automatic test_illegal();
    logic [3:0] sa, so; logic [31:0] ma, rd; logic dn, ex, er;
    do_txn(1'b0, 4'hF, 32'h12, 32'h11223344, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (dn !== 1'b1 || er !== 1'b1 || (sa | so) !== 4'h0 || rd !== 32'h0) begin
      bad++; $display("FAIL misalign_wr: got done=%b err=%b start=%h rdata=%h want 1 1 0 0",
                      dn, er, sa | so, rd); end
    do_txn(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (rd !== 32'hDEADABEF || er !== 1'b0) begin
      bad++; $display("FAIL misalign_keep: got rdata=%h err=%b want deadabef 0", rd, er); end
  endtask

  task automatic test_boundary();
    logic [3:0] sa, so; logic [31:0] ma, rd; logic dn, ex, er;
    do_txn(1'b1, 4'hF, 32'h3FC, 32'h12345678, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (sa !== 4'hF || er !== 1'b0) begin
      bad++; $display("FAIL top_wr: got start=%h err=%b want F 0", sa, er); end
    do_txn(1'b0, 4'h0, 32'h3FC, 32'h0, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (rd !== 32'h12345678 || er !== 1'b0 || dn !== 1'b1) begin
      bad++; $display("FAIL top_rd: got rdata=%h err=%b done=%b want 12345678 0 1", rd, er, dn); end
    do_txn(1'b0, 4'hF, 32'h400, 32'hFFFFFFFF, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (er !== 1'b1 || rd !== 32'h0 || (sa | so) !== 4'h0) begin
      bad++; $display("FAIL over_top: got err=%b rdata=%h start=%h want 1 0 0", er, rd, sa | so); end
    do_txn(1'b1, 4'h0, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0, sa, so, ma, dn, ex, er, rd);
    total++; if (er !== 1'b1 || rd !== 32'h0 || dn !== 1'b1) begin
      bad++; $display("FAIL far_addr: got err=%b rdata=%h done=%b want 1 0 1", er, rd, dn); end
  endtask

  task automatic test_random();
    logic [3:0] sa, so, we, exp_st; logic [31:0] ma, rd, a, wd, exp_rd; logic dn, ex, er;
    bit n;
    for (int i = 0; i < 40; i++) begin
      n  = 1'($urandom);
      we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      a  = rand_addr();
      wd = $urandom;
      exp_rd = ref_read(a);
      exp_st = is_legal(a) ? we : 4'h0;
      do_txn(n, we, a, wd, 1'($urandom), 1'($urandom), sa, so, ma, dn, ex, er, rd);
      total++; if (sa !== exp_st || so !== 4'h0 || dn !== 1'b1 || ex !== 1'b0 ||
                   er !== !is_legal(a) || rd !== exp_rd) begin
        bad++; $display("FAIL rand_%0d: r%0d a=%h got st=%h/%h done=%b extra=%b err=%b rd=%h want st=%h/0 1 0 err=%b rd=%h",
                        i, n, a, sa, so, dn, ex, er, rd, exp_st, !is_legal(a), exp_rd); end
    end
  endtask

  // Reset lands during ACCESS; the write carries the word's current value so either
  // outcome of the interrupted write leaves the reference model correct.
  task automatic test_reset_in_access();
    logic seen;
    drive(1'b1, 1'b1, 4'hF, 32'h20, ref_w[8]);
    @(posedge clk); #1;
    total++; if (bus.mem_start !== 4'hF) begin
      bad++; $display("FAIL rst_pre: got start=%h want F", bus.mem_start); end
    drive(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
    rst_n = 1'b0;
    #1;
    total++; if (bus.mem_start !== 4'h0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rst_async: got start=%h busy=%b want 0 0", bus.mem_start, bus.busy); end
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | bus.r0_done | bus.r1_done | bus.busy;
    end
    total++; if (seen !== 1'b0) begin
      bad++; $display("FAIL rst_quiet: got activity=%b want 0", seen); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  f_we [2];
    logic [31:0] f_a  [2];
    logic [31:0] f_wd [2];
    bit refresh [2];
    bit exp_next, n;
    int last_c, ndone;
    for (int r = 0; r < 2; r++) begin
      f_we[r] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      f_a[r]  = rand_addr();
      f_wd[r] = $urandom;
      refresh[r] = 1'b0;
      drive(1'(r), 1'b1, f_we[r], f_a[r], f_wd[r]);
    end
    exp_next = 1'b0; last_c = -100; ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++)
        if (refresh[r]) begin
          f_we[r] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
          f_a[r]  = rand_addr();
          f_wd[r] = $urandom;
          refresh[r] = 1'b0;
          drive(1'(r), 1'b1, f_we[r], f_a[r], f_wd[r]);
        end
      if (bus.r0_done && bus.r1_done) begin
        total++; bad++; $display("FAIL b2b_both: cycle %0d both done high", cyc);
      end else if (bus.r0_done || bus.r1_done) begin
        n = bus.r1_done;
        total++; if (n !== exp_next) begin
          bad++; $display("FAIL b2b_order: done %0d got r%0d want r%0d", ndone, n, exp_next); end
        if (ndone > 0) begin
          total++; if (cyc - last_c != 3) begin
            bad++; $display("FAIL b2b_gap: got %0d cycles want 3", cyc - last_c); end
        end
        total++; if ((n ? bus.r1_err : bus.r0_err) !== !is_legal(f_a[n]) ||
                     bus.rdata !== ref_read(f_a[n])) begin
          bad++; $display("FAIL b2b_data: r%0d a=%h got err=%b rd=%h want %b %h", n, f_a[n],
                          n ? bus.r1_err : bus.r0_err, bus.rdata, !is_legal(f_a[n]),
                          ref_read(f_a[n])); end
        ref_write(f_a[n], f_we[n], f_wd[n]);
        exp_next = !n; last_c = cyc; ndone++; refresh[n] = 1'b1;
      end
    end
    total++; if (ndone != 10) begin
      bad++; $display("FAIL b2b_count: got %0d dones want 10", ndone); end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h0;
    for (int i = 0; i < 256; i++) ref_w[i] = 32'h0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_byte_write();
    test_illegal();
    test_boundary();
    test_random();
    test_reset_in_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
